// File: rtl/core_pkg.sv
// Shared pipeline-control types for the RV32 core.
package core_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERROR    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/freeze control: load-use, EX redirects, data-memory waits
// with a timeout watchdog, plus saturating stall/flush counters.
//
// state       | meaning
// HZ_RUN      | normal issue; load-use and branch handling active
// HZ_MEM_WAIT | data memory has not answered; pipeline frozen, watchdog running
// HZ_ERROR    | watchdog expired; pipeline frozen until reset
module hazard_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             use_rs1_de,
    input  logic             use_rs2_de,
    input  logic [4:0]       rd_ex,
    input  logic             RUWr_ex,
    input  logic             DMRd_ex,
    input  logic             NextPCSrc_ex,
    input  logic             dm_req_me,
    input  logic             dm_ready_me,
    output logic             PCWr,
    output logic             IFDEWr,
    output logic             DEEXWr,
    output logic             EXMEWr,
    output logic             IFDEFlush,
    output logic             DEEXFlush,
    output logic             MEWBFlush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    hz_state_t         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait, load_use, stall_inc, flush_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == HZ_MEM_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

    assign mem_wait = dm_req_me && !dm_ready_me;
    assign load_use = DMRd_ex && RUWr_ex && (rd_ex != REG_ZERO) &&
                      ((use_rs1_de && (rs1_de == rd_ex)) ||
                       (use_rs2_de && (rs2_de == rd_ex)));

    always_comb begin
        state_nxt   = state;
        PCWr        = 1'b1;
        IFDEWr      = 1'b1;
        DEEXWr      = 1'b1;
        EXMEWr      = 1'b1;
        IFDEFlush   = 1'b0;
        DEEXFlush   = 1'b0;
        MEWBFlush   = 1'b0;
        mem_timeout = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state)
            HZ_RUN: begin
                if (mem_wait) state_nxt = HZ_MEM_WAIT;
            end
            HZ_MEM_WAIT: begin
                if (dm_ready_me) begin
                    state_nxt = HZ_RUN;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    state_nxt = HZ_ERROR;
                end
            end
            default: state_nxt = HZ_ERROR;
        endcase

        if (state == HZ_ERROR) begin
            {PCWr, IFDEWr, DEEXWr, EXMEWr} = 4'b0000;
            MEWBFlush   = 1'b1;
            mem_timeout = 1'b1;
        end else if (mem_wait) begin
            {PCWr, IFDEWr, DEEXWr, EXMEWr} = 4'b0000;
            MEWBFlush = 1'b1;
            stall_inc = 1'b1;
        end else if (NextPCSrc_ex) begin
            // The dependent DE instruction is flushed, so any load-use is moot.
            IFDEFlush = 1'b1;
            DEEXFlush = 1'b1;
            flush_inc = 1'b1;
        end else if (load_use) begin
            PCWr      = 1'b0;
            IFDEWr    = 1'b0;
            DEEXFlush = 1'b1;
            stall_inc = 1'b1;
        end

        if (rst) begin
            {PCWr, IFDEWr, DEEXWr, EXMEWr}   = 4'b0000;
            {IFDEFlush, DEEXFlush, MEWBFlush} = 3'b111;
            mem_timeout = 1'b0;
        end
    end

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
